// File: rtl/unquote_rx.sv
// Hex-quote receiver: folds pairs of ASCII hex characters into bytes.
// One byte of buffering; err pulses on bad characters, err_count saturates.
module unquote_rx #(
  parameter bit SKIP_WS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:8] a_data,
  input  logic       a_send,
  output logic       a_busy,
  output logic [1:8] b_data,
  output logic       b_send,
  input  logic       b_busy,
  output logic       err,
  output logic [1:8] err_count
);

  typedef enum logic [1:0] {
    HI  = 2'd0,
    LO  = 2'd1,
    OUT = 2'd2
  } state_t;

  state_t     state;
  logic [1:4] hi_nib;
  logic       ch_ok;
  logic [3:0] ch_nib;
  logic       ch_ws;
  logic [7:0] ch;

  assign ch = a_data;

  always_comb begin
    ch_ok  = 1'b0;
    ch_nib = 4'h0;
    unique case (1'b1)
      (ch >= 8'h30 && ch <= 8'h39): begin
        ch_ok  = 1'b1;
        ch_nib = ch[3:0];
      end
      (ch >= 8'h41 && ch <= 8'h46),
      (ch >= 8'h61 && ch <= 8'h66): begin
        ch_ok  = 1'b1;
        ch_nib = ch[3:0] + 4'd9;
      end
      default: ch_ok = 1'b0;
    endcase
  end

  assign ch_ws = (ch == 8'h20) || (ch == 8'h09) ||
                 (ch == 8'h0A) || (ch == 8'h0D);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HI;
      hi_nib    <= '0;
      a_busy    <= 1'b0;
      b_send    <= 1'b0;
      b_data    <= '0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= 1'b0;
      if (err && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
      case (state)
        HI: begin
          if (a_send) begin
            if (ch_ok) begin
              hi_nib <= ch_nib;
              state  <= LO;
            end else if (!(SKIP_WS && ch_ws)) begin
              err <= 1'b1;
            end
          end
        end
        LO: begin
          if (a_send) begin
            if (ch_ok) begin
              b_data <= {hi_nib, ch_nib};
              b_send <= 1'b1;
              a_busy <= 1'b1;
              state  <= OUT;
            end else begin
              err    <= 1'b1;
              hi_nib <= '0;
              state  <= HI;
            end
          end
        end
        OUT: begin
          if (!b_busy) begin
            b_send <= 1'b0;
            a_busy <= 1'b0;
            state  <= HI;
          end
        end
        default: state <= HI;
      endcase
    end
  end

endmodule
